// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the queue head toward decode.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request, small in-order fetch queue, redirect flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc_in,
    output logic [31:0]   pc_next,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    instr_fetch_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [1:0]       state_q, state_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];

    logic head_valid_c;
    logic req_valid_c;
    logic req_fire_c;
    logic push_c;
    logic pop_c;

    // Handshake qualifiers; the single outstanding request always has a free slot waiting for it
    always_comb begin
        head_valid_c = (count_q != '0) && !rst;
        req_valid_c  = (state_q == S_REQ) && (count_q < CNT_W'(DEPTH)) && !redirect && !rst;
        req_fire_c   = req_valid_c && bus.imem_req_ready;
        push_c       = (state_q == S_WAIT) && bus.imem_rsp_valid && !redirect && !rst;
        pop_c        = head_valid_c && bus.if_ready;
    end

    // Next PC toward the program counter: reset, then redirect, then advance on handshake
    always_comb begin
        pc_next = pc_in;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (req_fire_c) begin
            pc_next = pc_in + 32'd4;
        end
    end

    // Next-state logic for the request FSM and the fetch queue
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        fifo_d   = fifo_q;

        case (state_q)
            S_REQ: begin
                if (req_fire_c) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_in;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (push_c) begin
            fifo_d[wr_ptr_q] = '{pc: req_pc_q, instr: bus.imem_rsp_data};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // Outputs toward memory and decode
    always_comb begin
        bus.imem_req_valid = req_valid_c;
        bus.imem_req_addr  = {pc_in[31:2], 2'b00};
        bus.if_valid       = head_valid_c;
        bus.if_pc          = head_valid_c ? fifo_q[rd_ptr_q].pc    : 32'd0;
        bus.if_instr       = head_valid_c ? fifo_q[rd_ptr_q].instr : 32'd0;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch, stall, redirect, wrap and reset scenarios.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_ready;
    logic        if_ready_main;
    bit          rdy_on_rsp = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hs_count = 0;
    int   lat      = 1;
    exp_t sb[$];
    int   pop_cyc[$];

    instr_fetch_if ifc ();

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_reg),
        .pc_next    (pc_next),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .bus        (ifc)
    );

    assign ifc.imem_req_ready = req_ready;
    assign ifc.imem_rsp_valid = rsp_valid;
    assign ifc.imem_rsp_data  = rsp_data;
    assign ifc.if_ready       = rdy_on_rsp ? rsp_valid : if_ready_main;

    always #5 clk = ~clk;

    // Program counter register fed back from pc_next
    always @(posedge clk) begin
        pc_reg <= pc_next;
        cyc    <= cyc + 1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // Open the memory until `target` handshakes have happened; returns in the cycle after the last one
    task automatic wait_hs(input int target);
        int n = 0;
        @(negedge clk);
        req_ready = 1'b1;
        forever begin
            #2;
            if (hs_count >= target) break;
            if (n >= 60) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout: got %0d handshakes expected %0d", hs_count, target);
                break;
            end
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        req_ready = 1'b0;
    endtask

    // Wait for every expected entry to reach decode
    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Memory model: one response `lat` cycles after each handshake, data derived from the address
    initial begin : mem_model
        bit          pend = 1'b0;
        int          cnt  = 0;
        logic [31:0] addr = 32'd0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_word(addr);
                    pend      = 1'b0;
                end
            end
            #1;
            if (ifc.imem_req_valid && req_ready) begin
                if (pend) begin
                    checks++;
                    failures++;
                    $display("FAIL outstanding: got second request 0x%08h expected none", ifc.imem_req_addr);
                end
                pend = 1'b1;
                cnt  = lat;
                addr = ifc.imem_req_addr;
                hs_count++;
            end
        end
    end

    // Monitor: every entry accepted by decode is compared against the scoreboard head
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (ifc.if_valid && ifc.if_ready) begin
                pop_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got pc 0x%08h expected no entry", ifc.if_pc);
                end else begin
                    e = sb.pop_front();
                    check("if_pc", ifc.if_pc, e.pc);
                    check("if_instr", ifc.if_instr, e.instr);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        rst           = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'd0;
        req_ready     = 1'b1;
        if_ready_main = 1'b1;

        // Reset state, with memory ready to show the request is gated
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(ifc.if_valid), 32'd0);
        check("rst_if_pc", ifc.if_pc, 32'd0);
        check("rst_if_instr", ifc.if_instr, 32'd0);
        check("rst_pc_next", pc_next, RST_PC);
        req_ready = 1'b0;
        rst       = 1'b0;

        // Streaming fetch with 1-cycle memory
        pop_cyc.delete();
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        wait_hs(hs_count + 3);
        drain("drain_stream");
        check("pop_spacing_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
        check("pop_spacing_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
        check("idle_pc_next", pc_next, 32'hC);

        // Decode stalled: queue fills to two entries and requests stop
        if_ready_main = 1'b0;
        t = hs_count + 2;
        expect_fetch(32'hC);
        expect_fetch(32'h10);
        wait_hs(t);
        req_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("full_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        check("full_if_valid", 32'(ifc.if_valid), 32'd1);
        check("full_head_pc", ifc.if_pc, 32'hC);
        check("full_pc_next", pc_next, 32'h14);
        check("full_hs_count", 32'(hs_count), 32'(t));
        req_ready     = 1'b0;
        if_ready_main = 1'b1;
        drain("drain_full");

        // Simultaneous push and pop with one entry resident
        if_ready_main = 1'b0;
        expect_fetch(32'h14);
        wait_hs(hs_count + 1);
        repeat (2) @(negedge clk);
        #1;
        check("one_entry_valid", 32'(ifc.if_valid), 32'd1);
        rdy_on_rsp = 1'b1;
        expect_fetch(32'h18);
        expect_fetch(32'h1C);
        expect_fetch(32'h20);
        wait_hs(hs_count + 3);
        @(negedge clk);
        rdy_on_rsp    = 1'b0;
        if_ready_main = 1'b1;
        drain("drain_pushpop");

        // Redirect while waiting; the late response is dropped
        lat = 4;
        wait_hs(hs_count + 1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("drop_pc_next", pc_next, 32'h100);
        check("drop_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("drop_if_valid", 32'(ifc.if_valid), 32'd0);
        lat = 1;
        expect_fetch(32'h100);
        wait_hs(hs_count + 1);
        drain("drain_drop");

        // Redirect coincident with the response
        lat = 2;
        wait_hs(hs_count + 1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check("coin_pc_next", pc_next, 32'h200);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("coin_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        check("coin_req_addr", ifc.imem_req_addr, 32'h200);
        check("coin_if_valid", 32'(ifc.if_valid), 32'd0);
        lat = 1;
        expect_fetch(32'h200);
        wait_hs(hs_count + 1);
        drain("drain_coin");

        // PC wraps past the top of the address space
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect  = 1'b0;
        req_ready = 1'b1;
        #1;
        check("wrap_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        check("wrap_req_addr", ifc.imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_pc_next", pc_next, 32'h0);
        expect_fetch(32'hFFFF_FFFC);
        @(negedge clk);
        req_ready = 1'b0;
        drain("drain_wrap");
        check("wrap_pc_hold", pc_next, 32'h0);

        // Reset in the middle of a request; the response after release is ignored
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        lat      = 3;
        wait_hs(hs_count + 1);
        rst = 1'b1;
        #1;
        check("midrst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        check("midrst_pc_next", pc_next, RST_PC);
        check("midrst_if_valid", 32'(ifc.if_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        check("post_rst_req_addr", ifc.imem_req_addr, RST_PC);
        repeat (2) @(negedge clk);
        #1;
        check("late_rsp_ignored", 32'(ifc.if_valid), 32'd0);
        lat = 1;
        expect_fetch(RST_PC);
        wait_hs(hs_count + 1);
        drain("drain_rst");

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded while reset is asserted.
REQ-002 Parameter DEPTH, default 2, fetch-queue entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pc_in  input  32  current PC, from the program counter's pc_out.
REQ-006 pc_next  output  32  combinational next PC, drives the program counter's pc_input.
REQ-007 redirect  input  1  branch/jump redirect strobe.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 imem_req_valid  output  1  instruction-memory request valid.
REQ-010 imem_req_ready  input  1  memory accepts request.
REQ-011 imem_req_addr  output  32  word-aligned fetch address {pc_in[31:2],2'b00}.
REQ-012 imem_rsp_valid  input  1  read data valid, one cycle per request.
REQ-013 imem_rsp_data  input  32  instruction word.
REQ-014 if_valid  output  1  queue head valid toward decode.
REQ-015 if_ready  input  1  decode accepts head.
REQ-016 if_pc  output  32  PC of head entry; 0 when empty.
REQ-017 if_instr  output  32  instruction of head entry; 0 when empty.

Function
REQ-018 FSM states SHALL be REQ, WAIT, DROP; at most one memory request outstanding.
REQ-019 In REQ, imem_req_valid SHALL be 1 iff (count + 0) < DEPTH and redirect=0 and rst=0, where count = queue occupancy.
REQ-020 Request handshake (valid & ready) SHALL latch req_pc=pc_in, set pc_next=pc_in+4 (mod 2^32), and move to WAIT.
REQ-021 Without handshake or redirect, pc_next SHALL equal pc_in (PC holds).
REQ-022 In WAIT, imem_rsp_valid SHALL push {req_pc, imem_rsp_data} into the queue and return to REQ; imem_req_valid=0 in WAIT.
REQ-023 imem_rsp_valid is ignored in REQ; a response is never expected in the handshake cycle.
REQ-024 Queue push-slot SHALL be reserved at request time, so a push never meets a full queue.
REQ-025 if_valid SHALL be 1 iff queue non-empty; if_valid & if_ready pops head.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Latency: handshake in cycle N, response in cycle N+k (k>=1), if_valid high from cycle N+k+1.
REQ-028 redirect=1 SHALL flush the queue (count=0, if_valid=0 next cycle) and force pc_next=redirect_pc.
REQ-029 redirect in WAIT without imem_rsp_valid that cycle SHALL move to DROP.
REQ-030 redirect in WAIT with imem_rsp_valid SHALL discard that response and move to REQ.
REQ-031 In DROP, imem_rsp_valid SHALL be discarded and move to REQ; redirect in DROP stays DROP with updated pc_next.
REQ-032 redirect takes priority over push and pop in the same cycle; popped entry that cycle is still counted as consumed by decode.

Reset
REQ-033 rst SHALL have priority over redirect and all handshakes.
REQ-034 While rst=1: state=REQ, queue empty, pc_next=RESET_PC, imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
REQ-035 rst asserted during WAIT SHALL abandon the request; a late response after reset release in REQ is ignored.

Verification
REQ-036 Reset, ready=1, 1-cycle memory, if_ready=1 -> if_pc sequence 0x0,0x4,0x8 with matching instr words, one per two cycles.
REQ-037 if_ready=0 with DEPTH=2 -> exactly two entries queued, imem_req_valid stays 0, pc_next holds 0x8.
REQ-038 redirect to 0x100 while WAIT, response 3 cycles later -> response dropped, next if_pc=0x100.
REQ-039 redirect coincident with imem_rsp_valid in WAIT -> no push, pc_next=redirect_pc, next request addr=redirect_pc.
REQ-040 pc_in=0xFFFF_FFFC handshake -> pc_next=0x0000_0000.
REQ-041 rst mid-WAIT, response arrives after release -> ignored, first request addr=RESET_PC.
